atomic_bus_arbiter: RTL and testbench
=====================================

// Module: atomic_bus_arbiter
// PURPOSE
//  N_IDS-hart front end to the atomic memory controller: arbitrates per-hart bus requests (plain, LR/SC, AMO),
//  forwards one at a time with its hart id, routes ack/read data back to the granted hart.
//  Grant held from acceptance until downstream ack; round-robin fair.
// PARAMETERS
//  N_IDS       2   number of requesting harts (>=2); id width IDW = $clog2(N_IDS)
//  LOCK_CYCLES 16  max cycles an LR reservation lock is held (used only with ARB_LR_LOCK_EN)
// PORTS
//  i_clk            in   1         clock
//  i_rst            in   1         reset, synchronous, active-low
//  i_bus_en         in   N_IDS     per-hart request; held until that hart's o_ack
//  i_wr_en          in   N_IDS     per-hart write enable
//  i_wr_data        in   32*N_IDS  per-hart write data, hart k at [32k+:32]
//  i_addr           in   32*N_IDS  per-hart byte address
//  i_byte_en        in   4*N_IDS   per-hart byte enables
//  i_atomic         in   N_IDS     per-hart atomic qualifier
//  i_operation      in   7*N_IDS   per-hart funct7 ([6:2] = atomic opcode)
//  o_ack            out  N_IDS     one-cycle completion pulse to granted hart
//  o_rd_data        out  32*N_IDS  read data / SC result to granted hart
//  o_mem_bus_en     out  1         request to memory controller
//  o_mem_wr_en/_wr_data/_addr/_byte_en/_atomic/_operation  out  1/32/32/4/1/7  muxed granted fields
//  o_mem_id         out  IDW       granted hart id
//  i_mem_ack        in   1         controller completion pulse
//  i_mem_rd_data    in   32        controller read data
// BEHAVIOUR
//  - Reset (!i_rst at posedge): state=IDLE, grant=0, rr_last=N_IDS-1 (hart 0 wins first), lock cleared;
//    all outputs 0. Reset mid-transaction abandons it; no o_ack issued.
//  - FSM IDLE -> BUSY -> RELEASE -> IDLE.
//  - IDLE: if any i_bus_en, pick first requester searching rr_last+1 upward, wrapping at N_IDS; register grant; ->BUSY.
//    No request: stay. Min latency: i_bus_en seen cycle N -> o_mem_bus_en high cycle N+1.
//  - BUSY: o_mem_bus_en = !i_mem_ack (drops combinationally in ack cycle so controller, back in IDLE, cannot restart).
//    All o_mem_* fields = granted hart's inputs, o_mem_id = grant.
//    On i_mem_ack: o_ack[grant]=1, o_rd_data[grant]=i_mem_rd_data same cycle; rr_last<=grant; ->RELEASE.
//  - RELEASE: one bubble, requests ignored (hart drops i_bus_en the cycle after its ack); ->IDLE.
//  - Outside BUSY all o_mem_* = 0. Non-granted o_ack=0, o_rd_data=0 always.
//  - Granted hart dropping i_bus_en before ack is a protocol violation; grant and o_mem_bus_en held regardless.
//  - Requests arriving in BUSY/RELEASE wait; none lost; starvation bound = N_IDS-1 transactions.
// CONFIGURATION
//  ARB_LR_LOCK_EN defined: an ack for an LR (atomic && op[6:2]==LR) locks arbiter to that hart,
//    counter=LOCK_CYCLES, decremented every cycle. While locked IDLE grants only the owner; lock clears
//    when owner's next transaction acks or counter reaches 0. Other harts then resume round-robin.
//  Undefined: pure round-robin, no lock logic or counter synthesised.
// STRUCTURE
//  arvi_bus_pkg: arb_state_t enum {IDLE,BUSY,RELEASE}, LR/SC opcode constants shared with atomic.svh, id-width function.
//  Sub-module rr_picker #(N): combinational request vector + last -> one-hot/index grant + valid.
// TESTING
//  1. Single req hart1 addr 0x100 rd, mem acks 3 cycles later with 0xDEADBEEF -> o_mem_id=1, o_ack[1] pulse, o_rd_data[1]=0xDEADBEEF.
//  2. Harts 0,1 request continuously, immediate acks -> grants alternate 0,1,0,1; RELEASE bubble between each.
//  3. i_mem_ack cycle -> o_mem_bus_en=0 same cycle; controller never sees back-to-back request without bubble.
//  4. Hart1 AMOADD 0x200 while hart0 idle, hart0 requests in BUSY -> hart0 granted right after RELEASE.
//  5. ARB_LR_LOCK_EN: hart0 LR 0x40, hart1 req, hart0 SC 3 cycles later -> SC granted before hart1;
//     no SC in 16 cycles -> hart1 granted.
//  6. Assert !i_rst mid-BUSY -> next cycle all outputs 0, next grant goes to hart 0.

Source files
------------

// File: rtl/atomic_bus_arbiter_pkg.sv
// Shared types and constants for the atomic bus arbiter: FSM state encoding,
// LR/SC atomic opcodes and the hart-id width helper.
package atomic_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    localparam logic [4:0] AMO_LR = 5'b00010;
    localparam logic [4:0] AMO_SC = 5'b00011;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atomic_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request searching upward from last+1,
// wrapping at N. Purely combinational.
module rr_picker
    import atomic_bus_arbiter_pkg::*;
#(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant_oh,
    output logic [IDW-1:0] grant_idx,
    output logic           valid
);

    logic [IDW-1:0] cand;

    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDW'((32'(last) + i) % N);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                grant_idx = cand;
            end
        end
        grant_oh[grant_idx] = valid;
    end

endmodule

// File: rtl/atomic_bus_arbiter.sv
// N_IDS-hart round-robin front end to the atomic memory controller.
// Define ARB_LR_LOCK_EN to lock the arbiter to a hart after its LR completes.
module atomic_bus_arbiter
    import atomic_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_IDS       = 2,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned IDW        = id_width(N_IDS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_IDS-1:0]     i_bus_en,
    input  logic [N_IDS-1:0]     i_wr_en,
    input  logic [32*N_IDS-1:0]  i_wr_data,
    input  logic [32*N_IDS-1:0]  i_addr,
    input  logic [4*N_IDS-1:0]   i_byte_en,
    input  logic [N_IDS-1:0]     i_atomic,
    input  logic [7*N_IDS-1:0]   i_operation,
    output logic [N_IDS-1:0]     o_ack,
    output logic [32*N_IDS-1:0]  o_rd_data,
    output logic                 o_mem_bus_en,
    output logic                 o_mem_wr_en,
    output logic [31:0]          o_mem_wr_data,
    output logic [31:0]          o_mem_addr,
    output logic [3:0]           o_mem_byte_en,
    output logic                 o_mem_atomic,
    output logic [6:0]           o_mem_operation,
    output logic [IDW-1:0]       o_mem_id,
    input  logic                 i_mem_ack,
    input  logic [31:0]          i_mem_rd_data
);

    if (N_IDS < 2 || LOCK_CYCLES == 0) begin : g_param_check
        $error("atomic_bus_arbiter: N_IDS must be >= 2 and LOCK_CYCLES > 0");
    end

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d, rr_last_q, rr_last_d;
    logic [N_IDS-1:0]   grant_oh_q, grant_oh_d;
    logic [N_IDS-1:0]   pick_req, pick_oh;
    logic [IDW-1:0]     pick_idx;
    logic               pick_valid;
    logic               busy, done;

    logic               sel_wr_en, sel_atomic;
    logic [31:0]        sel_wr_data, sel_addr;
    logic [3:0]         sel_byte_en;
    logic [6:0]         sel_operation;

    assign busy = (state_q == BUSY);
    assign done = busy & i_mem_ack;

    always_comb begin
        sel_wr_en     = 1'b0;
        sel_wr_data   = '0;
        sel_addr      = '0;
        sel_byte_en   = '0;
        sel_atomic    = 1'b0;
        sel_operation = '0;
        for (int unsigned k = 0; k < N_IDS; k++) begin
            if (grant_q == IDW'(k)) begin
                sel_wr_en     = i_wr_en[k];
                sel_wr_data   = i_wr_data[32*k +: 32];
                sel_addr      = i_addr[32*k +: 32];
                sel_byte_en   = i_byte_en[4*k +: 4];
                sel_atomic    = i_atomic[k];
                sel_operation = i_operation[7*k +: 7];
            end
        end
    end

`ifdef ARB_LR_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);

    logic               lock_q, lock_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IDS-1:0]   owner_oh;

    assign owner_oh = N_IDS'(1) << owner_q;
    assign pick_req = lock_q ? (i_bus_en & owner_oh) : i_bus_en;

    // A fresh LR ack (re)arms the lock; otherwise it ends on the owner's next ack or timeout.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (done && sel_atomic && sel_operation[6:2] == AMO_LR) begin
            lock_d  = 1'b1;
            owner_d = grant_q;
            cnt_d   = CNT_W'(LOCK_CYCLES);
        end else if (lock_q) begin
            if ((done && grant_q == owner_q) || cnt_q == CNT_W'(1)) begin
                lock_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign pick_req = i_bus_en;
`endif

    rr_picker #(
        .N   (N_IDS),
        .IDW (IDW)
    ) u_picker (
        .req       (pick_req),
        .last      (rr_last_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_last_d  = rr_last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = BUSY;
                    grant_d    = pick_idx;
                    grant_oh_d = pick_oh;
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    state_d   = RELEASE;
                    rr_last_d = grant_q;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_last_q  <= IDW'(N_IDS - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_last_q  <= rr_last_d;
        end
    end

    // Request drops in the ack cycle itself so the controller cannot restart on it.
    assign o_mem_bus_en    = busy & ~i_mem_ack;
    assign o_mem_wr_en     = busy & sel_wr_en;
    assign o_mem_wr_data   = busy ? sel_wr_data : '0;
    assign o_mem_addr      = busy ? sel_addr : '0;
    assign o_mem_byte_en   = busy ? sel_byte_en : '0;
    assign o_mem_atomic    = busy & sel_atomic;
    assign o_mem_operation = busy ? sel_operation : '0;
    assign o_mem_id        = busy ? grant_q : '0;
    assign o_ack           = done ? grant_oh_q : '0;

    always_comb begin
        o_rd_data = '0;
        for (int unsigned k = 0; k < N_IDS; k++) begin
            if (done && grant_oh_q[k]) begin
                o_rd_data[32*k +: 32] = i_mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_atomic_bus_arbiter.sv
// Scoreboard bench for atomic_bus_arbiter: directed scenarios then random traffic,
// checked against a transaction-level arbitration model.
module tb_atomic_bus_arbiter;
    import atomic_bus_arbiter_pkg::*;

    localparam int unsigned NH   = 3;
    localparam int unsigned LOCK = 16;
    localparam int unsigned IDW  = id_width(NH);

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        at;
        logic [6:0]  op;
    } req_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        req_t           r;
    } exp_req_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_ack_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NH-1:0]       i_bus_en = '0, i_wr_en = '0, i_atomic = '0;
    logic [32*NH-1:0]    i_wr_data = '0, i_addr = '0;
    logic [4*NH-1:0]     i_byte_en = '0;
    logic [7*NH-1:0]     i_operation = '0;
    logic                i_mem_ack = 1'b0;
    logic [31:0]         i_mem_rd_data = '0;
    logic [NH-1:0]       o_ack;
    logic [32*NH-1:0]    o_rd_data;
    logic                o_mem_bus_en, o_mem_wr_en, o_mem_atomic;
    logic [31:0]         o_mem_wr_data, o_mem_addr;
    logic [3:0]          o_mem_byte_en;
    logic [6:0]          o_mem_operation;
    logic [IDW-1:0]      o_mem_id;

    atomic_bus_arbiter #(.N_IDS(NH), .LOCK_CYCLES(LOCK)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_bus_en(i_bus_en), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
        .i_addr(i_addr), .i_byte_en(i_byte_en), .i_atomic(i_atomic),
        .i_operation(i_operation), .o_ack(o_ack), .o_rd_data(o_rd_data),
        .o_mem_bus_en(o_mem_bus_en), .o_mem_wr_en(o_mem_wr_en),
        .o_mem_wr_data(o_mem_wr_data), .o_mem_addr(o_mem_addr),
        .o_mem_byte_en(o_mem_byte_en), .o_mem_atomic(o_mem_atomic),
        .o_mem_operation(o_mem_operation), .o_mem_id(o_mem_id),
        .i_mem_ack(i_mem_ack), .i_mem_rd_data(i_mem_rd_data)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0, n_pass = 0;
    exp_req_t    req_q[$];
    exp_ack_t    ack_q[$];

    // hart and controller stimulus state
    req_t        hreq[NH];
    bit          pend[NH], active[NH], keep[NH];
    bit          rand_en = 0;
    int          mem_delay = 0;
    int          mem_wait = 0;
    bit          mem_busy = 0, mem_seen = 0, mon_en = 0, in_txn = 0;
    bit          mem_fixed = 0;
    logic [31:0] mem_fixed_data = '0;

    // reference model: 0 = waiting for requests, 1 = transaction open, 2 = bubble
    int          m_phase = 0;
    int unsigned m_last = NH - 1, m_grant = 0;
    int          cyc = 0;
    bit          m_acked[NH];
    bit          m_lock = 0;
    int unsigned m_owner = 0;
    int          m_expire = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.wr   = 1'($urandom_range(1, 0));
        r.data = $urandom();
        r.addr = $urandom();
        r.be   = 4'($urandom_range(15, 0));
        r.at   = 1'($urandom_range(1, 0));
        r.op   = {5'($urandom_range(3, 0)), 2'($urandom_range(3, 0))};
        return r;
    endfunction

    task automatic model_step();
        logic [NH-1:0] allowed;
        cyc++;
        foreach (m_acked[k]) m_acked[k] = 0;
        if (!rst_n) begin
            m_phase = 0;
            m_last  = NH - 1;
            m_lock  = 0;
            return;
        end
        case (m_phase)
            0: begin
                allowed = i_bus_en;
                if (m_lock && cyc <= m_expire) allowed = allowed & (NH'(1) << m_owner);
                for (int unsigned i = 1; i <= NH; i++) begin
                    int unsigned k;
                    k = (m_last + i) % NH;
                    if (m_phase == 0 && allowed[k]) begin
                        m_grant = k;
                        m_phase = 1;
                        req_q.push_back({IDW'(k), hreq[k]});
                    end
                end
            end
            1: begin
                if (i_mem_ack) begin
                    m_acked[m_grant] = 1;
                    m_last = m_grant;
`ifdef ARB_LR_LOCK_EN
                    if (hreq[m_grant].at && hreq[m_grant].op[6:2] == AMO_LR) begin
                        m_lock   = 1;
                        m_owner  = m_grant;
                        m_expire = cyc + LOCK;
                    end else if (m_lock && m_grant == m_owner) begin
                        m_lock = 0;
                    end
`endif
                    m_phase = 2;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (!rst_n || i_mem_ack) begin
            i_mem_ack = 1'b0;
            mem_busy  = 0;
        end else begin
            if (mem_seen && !mem_busy) begin
                mem_busy = 1;
                mem_wait = (mem_delay < 0) ? int'($urandom_range(3, 0)) : mem_delay;
            end
            if (mem_busy) begin
                if (mem_wait == 0) begin
                    i_mem_ack     = 1'b1;
                    i_mem_rd_data = mem_fixed ? mem_fixed_data : $urandom();
                    ack_q.push_back({IDW'(m_grant), i_mem_rd_data});
                end else begin
                    mem_wait--;
                end
            end
        end
        for (int k = 0; k < NH; k++) begin
            if (!rst_n) begin
                active[k] = 0;
                pend[k]   = 0;
            end else if (active[k] && m_acked[k]) begin
                active[k] = 0;
            end else if (!active[k]) begin
                if (!pend[k] && keep[k]) pend[k] = 1;
                if (!pend[k] && rand_en && $urandom_range(3, 0) == 0) begin
                    hreq[k] = rand_req();
                    pend[k] = 1;
                end
                if (pend[k]) begin
                    active[k] = 1;
                    pend[k]   = 0;
                end
            end
            i_bus_en[k]            = active[k];
            i_wr_en[k]             = hreq[k].wr;
            i_wr_data[32*k +: 32]  = hreq[k].data;
            i_addr[32*k +: 32]     = hreq[k].addr;
            i_byte_en[4*k +: 4]    = hreq[k].be;
            i_atomic[k]            = hreq[k].at;
            i_operation[7*k +: 7]  = hreq[k].op;
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = (m_phase == 0) && !mem_busy && (req_q.size() == 0);
        for (int k = 0; k < NH; k++) if (active[k] || pend[k]) q = 0;
        return q;
    endfunction

    task automatic wait_idle(input int unsigned budget, input string name);
        int unsigned n = 0;
        do begin
            step();
            n++;
        end while (!quiet() && n < budget);
        n_checks++;
        if (quiet()) n_pass++;
        else $display("FAIL %s: traffic still pending after %0d cycles, expected drained", name, n);
    endtask

    // monitor: compares DUT outputs to scoreboard entries away from the clock edge
    always @(negedge clk) begin
        mem_seen = o_mem_bus_en;
        if (mon_en) begin
            logic [NH-1:0]    ea;
            logic [32*NH-1:0] er;
            exp_req_t         e;
            exp_ack_t         a;
            check("mem_bus_en", 128'(o_mem_bus_en), 128'((m_phase == 1) && !i_mem_ack));
            if (m_phase != 1) begin
                in_txn = 0;
                check("idle_fields_zero",
                      128'({o_mem_id, o_mem_wr_en, o_mem_wr_data, o_mem_addr,
                            o_mem_byte_en, o_mem_atomic, o_mem_operation}), 128'(0));
            end
            if (o_mem_bus_en && !in_txn) begin
                in_txn = 1;
                if (req_q.size() == 0) begin
                    check("unexpected_grant", 128'(o_mem_id), 128'hFFFF);
                end else begin
                    e = req_q.pop_front();
                    check("grant_fields",
                          128'({o_mem_id, o_mem_wr_en, o_mem_wr_data, o_mem_addr,
                                o_mem_byte_en, o_mem_atomic, o_mem_operation}), 128'(e));
                end
            end
            ea = '0;
            er = '0;
            if (ack_q.size() > 0) begin
                a = ack_q.pop_front();
                ea[a.id] = 1'b1;
                er[32*int'(a.id) +: 32] = a.data;
            end
            check("o_ack", 128'(o_ack), 128'(ea));
            check("o_rd_data", 128'(o_rd_data), 128'(er));
        end
    end

    initial begin
        for (int k = 0; k < NH; k++) begin
            hreq[k] = '0;
            pend[k] = 0;
            active[k] = 0;
            keep[k] = 0;
        end
        rst_n = 1'b0;
        step();
        mon_en = 1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // single read from hart 1, controller answers 3 cycles after seeing it
        mem_delay = 2;
        mem_fixed = 1;
        mem_fixed_data = 32'hDEADBEEF;
        hreq[1] = '{wr: 1'b0, data: 32'h0, addr: 32'h100, be: 4'hF, at: 1'b0, op: 7'h0};
        pend[1] = 1;
        wait_idle(40, "single_read");

        // harts 0 and 1 back-to-back with immediate acks
        mem_delay = 0;
        mem_fixed = 0;
        hreq[0] = '{wr: 1'b1, data: 32'h11110000, addr: 32'h10, be: 4'h3, at: 1'b0, op: 7'h0};
        keep[0] = 1;
        keep[1] = 1;
        repeat (24) step();
        keep[0] = 0;
        keep[1] = 0;
        wait_idle(40, "alternate");

        // hart 0 arrives while hart 1's AMOADD is in flight
        mem_delay = 3;
        hreq[1] = '{wr: 1'b1, data: 32'h5, addr: 32'h200, be: 4'hF, at: 1'b1, op: {5'b00000, 2'b00}};
        pend[1] = 1;
        repeat (3) step();
        hreq[0] = '{wr: 1'b0, data: 32'h0, addr: 32'h300, be: 4'hF, at: 1'b0, op: 7'h0};
        pend[0] = 1;
        wait_idle(40, "amo_then_wait");

`ifdef ARB_LR_LOCK_EN
        // LR then SC from hart 0 with hart 1 waiting; then an LR that times out
        mem_delay = 0;
        hreq[0] = '{wr: 1'b0, data: 32'h0, addr: 32'h40, be: 4'hF, at: 1'b1, op: {AMO_LR, 2'b00}};
        pend[0] = 1;
        wait_idle(40, "lr_lock");
        hreq[1] = '{wr: 1'b0, data: 32'h0, addr: 32'h80, be: 4'hF, at: 1'b0, op: 7'h0};
        pend[1] = 1;
        repeat (3) step();
        hreq[0] = '{wr: 1'b1, data: 32'h77, addr: 32'h40, be: 4'hF, at: 1'b1, op: {AMO_SC, 2'b00}};
        pend[0] = 1;
        wait_idle(40, "sc_before_other");
        hreq[0] = '{wr: 1'b0, data: 32'h0, addr: 32'h40, be: 4'hF, at: 1'b1, op: {AMO_LR, 2'b00}};
        pend[0] = 1;
        wait_idle(40, "lr_lock2");
        pend[1] = 1;
        wait_idle(60, "lock_timeout");
`endif

        // reset abandons an open transaction; afterwards hart 0 wins first
        mem_delay = 3;
        pend[0] = 1;
        wait_idle(40, "pre_reset_txn");
        pend[1] = 1;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("reset_bus_en", 128'(o_mem_bus_en), 128'(0));
        check("reset_ack", 128'({o_ack, o_rd_data}), 128'(0));
        mem_delay = 1;
        pend[0] = 1;
        pend[1] = 1;
        pend[2] = 1;
        wait_idle(60, "post_reset_order");

        // random traffic
        mem_delay = -1;
        rand_en = 1;
        repeat (3000) step();
        rand_en = 0;
        wait_idle(200, "random_drain");
        check("ack_queue_empty", 128'(ack_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
